// File: rtl/mac_seq_pkg.sv
// ---------------------------------------------------------------------------
// mac_seq_pkg
// Shared definitions for the dot-product sequencer that drives a MAC_16BIT
// hard block: the sequencer state encoding, the default term-counter width
// and the largest meaningful output shift of the MAC.
// ---------------------------------------------------------------------------
package mac_seq_pkg;

  // Default width of the term counter and of cfg_len.
  localparam int LEN_W_DEF = 8;

  // Largest shift the MAC output stage is designed for. Larger cfg_out_sel
  // values are still forwarded to the MAC untouched.
  localparam int OUT_SEL_MAX = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// ---------------------------------------------------------------------------
// mac_dot_seq
// Sequences one N-term dot product through a MAC_16BIT accumulator block.
// A job is started with a single-cycle start pulse, which latches the job
// configuration. Operand beats are accepted with a valid/ready handshake and
// forwarded combinationally to the MAC; the first beat of a job clears the
// accumulator (or preloads the rounding constant when rounding is enabled).
// After the last beat one drain cycle registers the MAC output, which is then
// held on res_data until the consumer accepts it.
//
// Ports
//   MAC_ACC_CLK, acc_ff_rstn       clock, asynchronous active-low reset
//   start, abort                   job request / job cancel
//   cfg_len[LEN_W]                 number of terms N (0 is rejected with err)
//   cfg_out_sel[6], cfg_tc,
//   cfg_rnd, cfg_sat               MAC output shift, signed, round, saturate
//   in_valid/in_ready,
//   in_oper[16], in_coef[16]       operand beat handshake
//   res_valid/res_ready,
//   res_data[16]                   result handshake
//   busy, err                      job in progress, bad-length pulse
//   MAC_* / EFPGA_MATHB_CLK_EN     MAC_16BIT control and operand outputs
//   MAC_OUT[16]                    MAC_16BIT result input
// The MAC-side ports connect to the single MAC_16BIT instance next to this
// sequencer.
// ---------------------------------------------------------------------------
module mac_dot_seq
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             MAC_ACC_CLK,
  input  logic             acc_ff_rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [5:0]       cfg_out_sel,
  input  logic             cfg_tc,
  input  logic             cfg_rnd,
  input  logic             cfg_sat,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_oper,
  input  logic [15:0]      in_coef,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             busy,
  output logic             err,
  output logic [15:0]      MAC_OPER_DATA,
  output logic [15:0]      MAC_COEF_DATA,
  output logic             EFPGA_MATHB_CLK_EN,
  output logic             MAC_ACC_CLEAR,
  output logic             MAC_ACC_RND,
  output logic             MAC_ACC_SAT,
  output logic [5:0]       MAC_OUT_SEL,
  output logic             MAC_TC,
  input  logic [15:0]      MAC_OUT
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  seq_state_t       r_state;
  seq_state_t       w_nextState;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [5:0]       r_outSel;
  logic             r_tc;
  logic             r_rnd;
  logic             r_sat;
  logic             r_first;
  logic [15:0]      r_resData;
  logic             r_resValid;
  logic             r_err;
  logic             w_startOk;
  logic             w_beat;
  logic             w_lastBeat;

  // Abort outranks start in IDLE, so a simultaneous abort suppresses both
  // the job launch and the bad-length error.
  assign w_startOk  = (r_state == IDLE) && start && !abort && (cfg_len != '0);

  // The counter stops at N-1 instead of wrapping, so the largest N fits.
  assign w_lastBeat = w_beat && (r_cnt == (r_len - LEN_ONE));

  // State register.
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_startOk) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_lastBeat) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        w_nextState = abort ? IDLE : HOLD;
      end
      HOLD: begin
        if (abort || res_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic. Operands are forced to zero outside beat cycles so that
  // the MAC sees quiet inputs while its clock enable is low. An aborting RUN
  // cycle refuses the beat so the accumulator is left untouched.
  always_comb begin
    in_ready           = 1'b0;
    w_beat             = 1'b0;
    EFPGA_MATHB_CLK_EN = 1'b0;
    MAC_OPER_DATA      = '0;
    MAC_COEF_DATA      = '0;
    MAC_ACC_CLEAR      = 1'b0;
    MAC_ACC_RND        = 1'b0;
    busy               = (r_state != IDLE);
    if ((r_state == RUN) && !abort) begin
      in_ready = 1'b1;
    end
    w_beat = in_ready && in_valid;
    if (w_beat) begin
      EFPGA_MATHB_CLK_EN = 1'b1;
      MAC_OPER_DATA      = in_oper;
      MAC_COEF_DATA      = in_coef;
      MAC_ACC_CLEAR      = r_first && !r_rnd;
      MAC_ACC_RND        = r_first && r_rnd;
    end
  end

  // Job configuration, term counter and first-beat flag. The configuration
  // is only captured on an accepted start, so it stays stable for the whole
  // job and keeps its last value while idle.
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r_cnt    <= '0;
      r_len    <= '0;
      r_outSel <= '0;
      r_tc     <= 1'b0;
      r_rnd    <= 1'b0;
      r_sat    <= 1'b0;
      r_first  <= 1'b0;
    end else if (w_startOk) begin
      r_cnt    <= '0;
      r_len    <= cfg_len;
      r_outSel <= cfg_out_sel;
      r_tc     <= cfg_tc;
      r_rnd    <= cfg_rnd;
      r_sat    <= cfg_sat;
      r_first  <= 1'b1;
    end else if (w_beat) begin
      r_first <= 1'b0;
      if (!w_lastBeat) begin
        r_cnt <= r_cnt + LEN_ONE;
      end
    end
  end

  // Result register, result valid and error pulse. MAC_OUT is captured in
  // the drain cycle, one edge after the final accumulate has landed.
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r_resData  <= '0;
      r_resValid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= (r_state == IDLE) && start && !abort && (cfg_len == '0);
      r_resValid <= (w_nextState == HOLD);
      if ((r_state == DRAIN) && !abort) begin
        r_resData <= MAC_OUT;
      end
    end
  end

  assign res_data    = r_resData;
  assign res_valid   = r_resValid;
  assign err         = r_err;
  assign MAC_OUT_SEL = r_outSel;
  assign MAC_TC      = r_tc;
  assign MAC_ACC_SAT = r_sat;

endmodule

// File: tb/tb_mac_dot_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mac_dot_seq
// Self-checking bench for mac_dot_seq. A behavioural MAC_16BIT stands in for
// the hard block; expected results come from a plain-arithmetic dot-product
// reference (sum of products, rounding constant, shift, saturate).
// ---------------------------------------------------------------------------
module tb_mac_dot_seq;

  localparam int LW = 8;

  logic          MAC_ACC_CLK = 1'b0;
  logic          acc_ff_rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [5:0]    cfg_out_sel = '0;
  logic          cfg_tc = 1'b0;
  logic          cfg_rnd = 1'b0;
  logic          cfg_sat = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_oper = '0;
  logic [15:0]   in_coef = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [15:0]   res_data;
  logic          busy;
  logic          err;
  logic [15:0]   MAC_OPER_DATA;
  logic [15:0]   MAC_COEF_DATA;
  logic          EFPGA_MATHB_CLK_EN;
  logic          MAC_ACC_CLEAR;
  logic          MAC_ACC_RND;
  logic          MAC_ACC_SAT;
  logic [5:0]    MAC_OUT_SEL;
  logic          MAC_TC;
  logic [15:0]   MAC_OUT;

  int total = 0;
  int bad = 0;

  // Terms of the job currently being driven.
  logic [15:0] operQ[$];
  logic [15:0] coefQ[$];

  // Directed vectors with hand-derived expected results.
  typedef struct packed {
    logic [7:0]       n;
    logic             tc;
    logic             rnd;
    logic             sat;
    logic [5:0]       sel;
    logic [3:0][15:0] oper;
    logic [3:0][15:0] coef;
    logic [15:0]      expRes;
  } vec_t;

  vec_t vecs[9];

  always #5 MAC_ACC_CLK = ~MAC_ACC_CLK;

  mac_dot_seq #(.LEN_W(LW)) dut (
    .MAC_ACC_CLK        (MAC_ACC_CLK),
    .acc_ff_rstn        (acc_ff_rstn),
    .start              (start),
    .abort              (abort),
    .cfg_len            (cfg_len),
    .cfg_out_sel        (cfg_out_sel),
    .cfg_tc             (cfg_tc),
    .cfg_rnd            (cfg_rnd),
    .cfg_sat            (cfg_sat),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_oper            (in_oper),
    .in_coef            (in_coef),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .busy               (busy),
    .err                (err),
    .MAC_OPER_DATA      (MAC_OPER_DATA),
    .MAC_COEF_DATA      (MAC_COEF_DATA),
    .EFPGA_MATHB_CLK_EN (EFPGA_MATHB_CLK_EN),
    .MAC_ACC_CLEAR      (MAC_ACC_CLEAR),
    .MAC_ACC_RND        (MAC_ACC_RND),
    .MAC_ACC_SAT        (MAC_ACC_SAT),
    .MAC_OUT_SEL        (MAC_OUT_SEL),
    .MAC_TC             (MAC_TC),
    .MAC_OUT            (MAC_OUT)
  );

  // Behavioural MAC_16BIT: a wide accumulator that loads on CLEAR, loads the
  // rounding half-LSB plus product on RND, and otherwise adds the product.
  // It is deliberately not reset, so a stale sum survives a sequencer reset.
  logic signed [47:0] macAcc = '0;
  logic signed [47:0] macProd;
  logic signed [47:0] macRndConst;
  logic signed [47:0] macShift;

  always_comb begin
    macProd     = '0;
    macRndConst = '0;
    if (MAC_TC) begin
      macProd = $signed({{32{MAC_OPER_DATA[15]}}, MAC_OPER_DATA}) *
                $signed({{32{MAC_COEF_DATA[15]}}, MAC_COEF_DATA});
    end else begin
      macProd = $signed({32'b0, MAC_OPER_DATA} * {32'b0, MAC_COEF_DATA});
    end
    if (MAC_OUT_SEL != 6'd0) begin
      macRndConst = 48'sd1 <<< (MAC_OUT_SEL - 6'd1);
    end
  end

  always @(posedge MAC_ACC_CLK) begin
    if (EFPGA_MATHB_CLK_EN) begin
      if (MAC_ACC_CLEAR)    macAcc <= macProd;
      else if (MAC_ACC_RND) macAcc <= macRndConst + macProd;
      else                  macAcc <= macAcc + macProd;
    end
  end

  always_comb begin
    macShift = MAC_TC ? (macAcc >>> MAC_OUT_SEL) : (macAcc >> MAC_OUT_SEL);
    MAC_OUT  = macShift[15:0];
    if (MAC_ACC_SAT && MAC_TC && (macShift > 48'sd32767))       MAC_OUT = 16'h7FFF;
    else if (MAC_ACC_SAT && MAC_TC && (macShift < -48'sd32768)) MAC_OUT = 16'h8000;
    else if (MAC_ACC_SAT && !MAC_TC && (macShift > 48'sd65535)) MAC_OUT = 16'hFFFF;
  end

  // Reference dot product over the queued terms, straight from the rules.
  function automatic logic [15:0] refDot(input int n, input bit tc, input bit rnd,
                                         input bit sat, input int sel);
    longint sum = 0;
    for (int i = 0; i < n; i++) begin
      if (tc) sum += longint'($signed(operQ[i])) * longint'($signed(coefQ[i]));
      else    sum += longint'(operQ[i]) * longint'(coefQ[i]);
    end
    if (rnd && (sel > 0)) sum += longint'(1) << (sel - 1);
    sum = sum >>> sel;
    if (sat && tc && (sum > 32767))   sum = 32767;
    if (sat && tc && (sum < -32768))  sum = -32768;
    if (sat && !tc && (sum > 65535))  sum = 65535;
    return sum[15:0];
  endfunction

  // Single comparison: counts every call and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge MAC_ACC_CLK);
    #1;
  endtask

  // Everything that must sit at its reset value.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},     busy, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_en"},       EFPGA_MATHB_CLK_EN, 0);
    checkOutput({tag, "_clear"},    MAC_ACC_CLEAR, 0);
    checkOutput({tag, "_rnd"},      MAC_ACC_RND, 0);
    checkOutput({tag, "_oper"},     MAC_OPER_DATA, 0);
    checkOutput({tag, "_coef"},     MAC_COEF_DATA, 0);
    checkOutput({tag, "_out_sel"},  MAC_OUT_SEL, 0);
    checkOutput({tag, "_tc"},       MAC_TC, 0);
    checkOutput({tag, "_sat"},      MAC_ACC_SAT, 0);
    checkOutput({tag, "_res_valid"},res_valid, 0);
    checkOutput({tag, "_res_data"}, res_data, 0);
    checkOutput({tag, "_err"},      err, 0);
  endtask

  // Load the terms of a directed vector into the job queues.
  task automatic loadVec(input int v);
    operQ.delete();
    coefQ.delete();
    for (int i = 0; i < int'(vecs[v].n); i++) begin
      operQ.push_back(vecs[v].oper[i]);
      coefQ.push_back(vecs[v].coef[i]);
    end
  endtask

  // Run one complete job from the queued terms. gap idles in_valid before
  // every beat, readyDelay holds res_ready low in HOLD, abortHold cancels the
  // job in HOLD instead of accepting it, pokeStart raises start during gaps.
  task automatic applyStimulus(input int n, input bit tc, input bit rnd,
                               input bit sat, input logic [5:0] sel,
                               input int gap, input int readyDelay,
                               input bit abortHold, input bit pokeStart,
                               output logic [15:0] got);
    logic [15:0] held;
    cfg_len     = LW'(n);
    cfg_out_sel = sel;
    cfg_tc      = tc;
    cfg_rnd     = rnd;
    cfg_sat     = sat;
    start       = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("out_sel_latched", MAC_OUT_SEL, sel);
    checkOutput("tc_latched", MAC_TC, tc);
    checkOutput("sat_latched", MAC_ACC_SAT, sat);

    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        start = pokeStart;
        cfg_len = LW'(1);
        cfg_out_sel = sel ^ 6'h3F;
        #1;
        checkOutput("gap_en", EFPGA_MATHB_CLK_EN, 0);
        checkOutput("gap_oper", MAC_OPER_DATA, 0);
        stepCycle();
        start = 1'b0;
        if (pokeStart) checkOutput("start_ignored_sel", MAC_OUT_SEL, sel);
      end
      in_valid = 1'b1;
      in_oper  = operQ[i];
      in_coef  = coefQ[i];
      #1;
      checkOutput("beat_ready", in_ready, 1);
      checkOutput("beat_en", EFPGA_MATHB_CLK_EN, 1);
      checkOutput("beat_oper", MAC_OPER_DATA, operQ[i]);
      checkOutput("beat_coef", MAC_COEF_DATA, coefQ[i]);
      checkOutput("beat_clear", MAC_ACC_CLEAR, (i == 0) && !rnd);
      checkOutput("beat_rnd", MAC_ACC_RND, (i == 0) && rnd);
      stepCycle();
    end

    // Drain cycle: nothing accepted, no result yet.
    in_valid = 1'b0;
    in_oper  = '0;
    in_coef  = '0;
    #1;
    checkOutput("drain_ready", in_ready, 0);
    checkOutput("drain_en", EFPGA_MATHB_CLK_EN, 0);
    checkOutput("drain_valid", res_valid, 0);
    stepCycle();
    checkOutput("valid_latency", res_valid, 1);
    for (int w = 0; (w < 8) && (res_valid !== 1'b1); w++) stepCycle();
    if (res_valid !== 1'b1) begin
      checkOutput("res_valid_timeout", res_valid, 1);
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      got = res_data;
      return;
    end
    got  = res_data;
    held = res_data;

    // HOLD: result must not move while the consumer stalls.
    for (int d = 0; d < readyDelay; d++) begin
      stepCycle();
      checkOutput("hold_valid", res_valid, 1);
      checkOutput("hold_data", res_data, held);
      checkOutput("hold_en", EFPGA_MATHB_CLK_EN, 0);
    end

    if (abortHold) begin
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      checkOutput("abort_hold_valid", res_valid, 0);
      checkOutput("abort_hold_busy", busy, 0);
    end else begin
      res_ready = 1'b1;
      stepCycle();
      res_ready = 1'b0;
      checkOutput("done_valid", res_valid, 0);
      checkOutput("done_busy", busy, 0);
    end
  endtask

  // Hang guard.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] mask;
    int          n;
    bit          tc, rnd, sat;
    logic [5:0]  sel;

    // Directed vector table.
    vecs[0] = '{n:8'd4, tc:1'b0, rnd:1'b0, sat:1'b0, sel:6'd0,
                oper:{16'd4, 16'd3, 16'd2, 16'd1}, coef:{4{16'd1}}, expRes:16'h000A};
    vecs[1] = '{n:8'd3, tc:1'b1, rnd:1'b0, sat:1'b0, sel:6'd0,
                oper:{16'd0, {3{16'hFFFF}}}, coef:{16'd0, {3{16'd1}}}, expRes:16'hFFFD};
    vecs[2] = '{n:8'd2, tc:1'b1, rnd:1'b0, sat:1'b1, sel:6'd0,
                oper:{32'd0, {2{16'h7FFF}}}, coef:{32'd0, {2{16'h7FFF}}}, expRes:16'h7FFF};
    vecs[3] = '{n:8'd2, tc:1'b1, rnd:1'b0, sat:1'b1, sel:6'd0,
                oper:{32'd0, {2{16'h8000}}}, coef:{32'd0, {2{16'h7FFF}}}, expRes:16'h8000};
    vecs[4] = '{n:8'd2, tc:1'b0, rnd:1'b0, sat:1'b1, sel:6'd0,
                oper:{32'd0, {2{16'hFFFF}}}, coef:{32'd0, {2{16'hFFFF}}}, expRes:16'hFFFF};
    vecs[5] = '{n:8'd2, tc:1'b0, rnd:1'b0, sat:1'b0, sel:6'd0,
                oper:{32'd0, {2{16'hFFFF}}}, coef:{32'd0, {2{16'hFFFF}}}, expRes:16'h0002};
    vecs[6] = '{n:8'd3, tc:1'b0, rnd:1'b1, sat:1'b0, sel:6'd4,
                oper:{16'd0, {3{16'd8}}}, coef:{16'd0, {3{16'd1}}}, expRes:16'h0002};
    vecs[7] = '{n:8'd1, tc:1'b0, rnd:1'b0, sat:1'b0, sel:6'd0,
                oper:{48'd0, 16'd5}, coef:{48'd0, 16'd7}, expRes:16'h0023};
    vecs[8] = '{n:8'd1, tc:1'b0, rnd:1'b0, sat:1'b0, sel:6'd30,
                oper:{48'd0, 16'hFFFF}, coef:{48'd0, 16'hFFFF}, expRes:16'h0003};

    // Reset state.
    #12;
    checkResetOutputs("reset");
    stepCycle();
    acc_ff_rstn = 1'b1;
    stepCycle();

    // Zero-length start: err pulses for exactly one cycle, no job.
    cfg_len = '0;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("err_pulse", err, 1);
    checkOutput("err_not_busy", busy, 0);
    stepCycle();
    checkOutput("err_single", err, 0);

    // Abort and start together in IDLE: abort wins.
    cfg_len = LW'(3);
    start = 1'b1;
    abort = 1'b1;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort_wins_busy", busy, 0);
    checkOutput("abort_wins_err", err, 0);

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      loadVec(v);
      applyStimulus(int'(vecs[v].n), vecs[v].tc, vecs[v].rnd, vecs[v].sat,
                    vecs[v].sel, 0, 0, 1'b0, 1'b0, got);
      checkOutput($sformatf("vec%0d_result", v), got, vecs[v].expRes);
    end

    // Beat gaps of 3 cycles and a 5-cycle consumer stall.
    loadVec(0);
    applyStimulus(4, 1'b0, 1'b0, 1'b0, 6'd0, 3, 5, 1'b0, 1'b0, got);
    checkOutput("gap_stall_result", got, 16'h000A);

    // Abort after 2 of 5 beats, then a fresh N=1 job with no stale sum.
    operQ = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    coefQ = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd9};
    cfg_len = LW'(5);
    cfg_rnd = 1'b0;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_oper  = operQ[i];
      in_coef  = coefQ[i];
      stepCycle();
    end
    abort = 1'b1;
    #1;
    checkOutput("abort_run_en", EFPGA_MATHB_CLK_EN, 0);
    stepCycle();
    abort = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("abort_run_busy", busy, 0);
    checkOutput("abort_run_valid", res_valid, 0);
    checkOutput("abort_run_en_after", EFPGA_MATHB_CLK_EN, 0);
    loadVec(7);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 6'd0, 0, 0, 1'b0, 1'b0, got);
    checkOutput("after_abort_result", got, 16'h0023);

    // Abort while the result is held.
    loadVec(0);
    applyStimulus(4, 1'b0, 1'b0, 1'b0, 6'd0, 0, 2, 1'b1, 1'b0, got);
    checkOutput("abort_hold_result", got, 16'h000A);

    // Start while busy is ignored (pokes during gap cycles).
    loadVec(6);
    applyStimulus(3, 1'b0, 1'b1, 1'b0, 6'd4, 1, 0, 1'b0, 1'b1, got);
    checkOutput("start_busy_result", got, 16'h0002);

    // Reset in the middle of RUN, then a job that must start from CLEAR.
    loadVec(0);
    cfg_len = LW'(4);
    cfg_out_sel = 6'd3;
    cfg_tc = 1'b1;
    cfg_sat = 1'b1;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_oper  = operQ[i];
      in_coef  = coefQ[i];
      stepCycle();
    end
    #2;
    acc_ff_rstn = 1'b0;
    #1;
    checkResetOutputs("midrun_reset");
    in_valid = 1'b0;
    stepCycle();
    acc_ff_rstn = 1'b1;
    stepCycle();
    applyStimulus(4, 1'b0, 1'b0, 1'b0, 6'd0, 0, 0, 1'b0, 1'b0, got);
    checkOutput("post_reset_result", got, 16'h000A);

    // Largest N: counter must reach N-1 without wrapping.
    operQ.delete();
    coefQ.delete();
    for (int i = 0; i < 255; i++) begin
      operQ.push_back(16'd1);
      coefQ.push_back(16'd1);
    end
    applyStimulus(255, 1'b0, 1'b0, 1'b0, 6'd0, 0, 0, 1'b0, 1'b0, got);
    checkOutput("max_len_result", got, 16'h00FF);

    // Randomized jobs against the reference dot product.
    for (int j = 0; j < 30; j++) begin
      n    = int'($urandom_range(1, 8));
      tc   = 1'($urandom_range(0, 1));
      rnd  = 1'($urandom_range(0, 1));
      sat  = 1'($urandom_range(0, 1));
      sel  = 6'($urandom_range(0, 24));
      mask = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0FFF;
      operQ.delete();
      coefQ.delete();
      for (int i = 0; i < n; i++) begin
        operQ.push_back(16'($urandom) & mask);
        coefQ.push_back(16'($urandom) & mask);
      end
      applyStimulus(n, tc, rnd, sat, sel, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), 1'b0, 1'b0, got);
      checkOutput($sformatf("rand%0d_result", j), got, refDot(n, tc, rnd, sat, int'(sel)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
